// File: rtl/s_axil_regfile.sv
// rtl/s_axil_regfile.sv - AXI-Lite slave register file with flattened register outputs and write strobes
// Optional: define S_AXIL_REGFILE_SLVERR_EN to answer out-of-range accesses with SLVERR.
module s_axil_regfile #(
    parameter int S_AXI_ADDR_WIDTH = 8,
    parameter int S_AXI_DATA_WIDTH = 32,
    parameter int NUM_REGS         = 16
) (
    input  logic                               ACLK,
    input  logic                               ARESET,
    input  logic [S_AXI_ADDR_WIDTH-1:0]        AWADDR,
    input  logic                               AWVALID,
    output logic                               AWREADY,
    input  logic [S_AXI_DATA_WIDTH-1:0]        WDATA,
    input  logic [S_AXI_DATA_WIDTH/8-1:0]      WSTRB,
    input  logic                               WVALID,
    output logic                               WREADY,
    output logic [1:0]                         BRESP,
    output logic                               BVALID,
    input  logic                               BREADY,
    input  logic [S_AXI_ADDR_WIDTH-1:0]        ARADDR,
    input  logic                               ARVALID,
    output logic                               ARREADY,
    output logic [S_AXI_DATA_WIDTH-1:0]        RDATA,
    output logic [1:0]                         RRESP,
    output logic                               RVALID,
    input  logic                               RREADY,
    output logic [NUM_REGS*S_AXI_DATA_WIDTH-1:0] reg_out,
    output logic [NUM_REGS-1:0]                wr_pulse
);

    localparam int DW       = S_AXI_DATA_WIDTH;
    localparam int NB       = DW / 8;
    localparam int ADDR_LSB = $clog2(NB);
    localparam int IDX_W    = S_AXI_ADDR_WIDTH - ADDR_LSB;
    localparam logic [IDX_W:0] NUM_REGS_L = (IDX_W + 1)'(NUM_REGS);

    logic [NUM_REGS-1:0][DW-1:0] regs_q, regs_d;
    logic [NUM_REGS-1:0]         wr_pulse_q, wr_pulse_d;
    logic                        aw_held_q, w_held_q;
    logic [IDX_W-1:0]            awidx_q;
    logic [DW-1:0]               wdata_q;
    logic [NB-1:0]               wstrb_q;
    logic                        bvalid_q;
    logic                        rvalid_q;
    logic [DW-1:0]               rdata_q;
    logic [DW-1:0]               rd_word;
    logic [IDX_W-1:0]            aridx;
    logic                        aw_hs, w_hs, ar_hs, commit;
    logic                        w_in_range, r_in_range;
    logic                        unused_addr_bits;

    // Byte-offset bits never select anything; only the word index matters.
    assign unused_addr_bits = &{1'b0, AWADDR[ADDR_LSB-1:0], ARADDR[ADDR_LSB-1:0]};

    assign AWREADY = !aw_held_q && !bvalid_q;
    assign WREADY  = !w_held_q && !bvalid_q;
    assign ARREADY = !rvalid_q;
    assign aw_hs   = AWVALID && AWREADY;
    assign w_hs    = WVALID && WREADY;
    assign ar_hs   = ARVALID && ARREADY;
    assign commit  = aw_held_q && w_held_q;
    assign aridx   = ARADDR[S_AXI_ADDR_WIDTH-1:ADDR_LSB];

    assign w_in_range = {1'b0, awidx_q} < NUM_REGS_L;
    assign r_in_range = {1'b0, aridx} < NUM_REGS_L;

    assign BVALID   = bvalid_q;
    assign RVALID   = rvalid_q;
    assign RDATA    = rdata_q;
    assign reg_out  = regs_q;
    assign wr_pulse = wr_pulse_q;

    always_comb begin
        regs_d     = regs_q;
        wr_pulse_d = '0;
        if (commit && w_in_range) begin
            for (int k = 0; k < NUM_REGS; k++) begin
                if (awidx_q == IDX_W'(k)) begin
                    wr_pulse_d[k] = 1'b1;
                    for (int b = 0; b < NB; b++) begin
                        if (wstrb_q[b]) begin
                            regs_d[k][b*8 +: 8] = wdata_q[b*8 +: 8];
                        end
                    end
                end
            end
        end
    end

    // Out-of-range indices match no register and read back as zero.
    always_comb begin
        rd_word = '0;
        for (int k = 0; k < NUM_REGS; k++) begin
            if (aridx == IDX_W'(k)) begin
                rd_word = regs_q[k];
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            regs_q     <= '0;
            wr_pulse_q <= '0;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            awidx_q    <= '0;
            wdata_q    <= '0;
            wstrb_q    <= '0;
            bvalid_q   <= 1'b0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
        end else begin
            regs_q     <= regs_d;
            wr_pulse_q <= wr_pulse_d;
            if (aw_hs) begin
                aw_held_q <= 1'b1;
                awidx_q   <= AWADDR[S_AXI_ADDR_WIDTH-1:ADDR_LSB];
            end
            if (w_hs) begin
                w_held_q <= 1'b1;
                wdata_q  <= WDATA;
                wstrb_q  <= WSTRB;
            end
            if (commit) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bvalid_q  <= 1'b1;
            end else if (bvalid_q && BREADY) begin
                bvalid_q <= 1'b0;
            end
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rd_word;
            end else if (rvalid_q && RREADY) begin
                rvalid_q <= 1'b0;
            end
        end
    end

`ifdef S_AXIL_REGFILE_SLVERR_EN
    logic [1:0] bresp_q, rresp_q;

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            bresp_q <= 2'b00;
            rresp_q <= 2'b00;
        end else begin
            if (commit) begin
                bresp_q <= w_in_range ? 2'b00 : 2'b10;
            end
            if (ar_hs) begin
                rresp_q <= r_in_range ? 2'b00 : 2'b10;
            end
        end
    end

    assign BRESP = bresp_q;
    assign RRESP = rresp_q;
`else
    logic unused_r_range;

    assign unused_r_range = r_in_range;
    assign BRESP = 2'b00;
    assign RRESP = 2'b00;
`endif

endmodule

// File: tb/tb_s_axil_regfile.sv
// tb/tb_s_axil_regfile.sv - scoreboard bench for s_axil_regfile (NUM_REGS=4, 32-bit data)
module tb_s_axil_regfile;

    logic         ACLK = 1'b0;
    logic         ARESET;
    logic [7:0]   AWADDR;
    logic         AWVALID;
    logic         AWREADY;
    logic [31:0]  WDATA;
    logic [3:0]   WSTRB;
    logic         WVALID;
    logic         WREADY;
    logic [1:0]   BRESP;
    logic         BVALID;
    logic         BREADY;
    logic [7:0]   ARADDR;
    logic         ARVALID;
    logic         ARREADY;
    logic [31:0]  RDATA;
    logic [1:0]   RRESP;
    logic         RVALID;
    logic         RREADY;
    logic [127:0] reg_out;
    logic [3:0]   wr_pulse;

`ifdef S_AXIL_REGFILE_SLVERR_EN
    localparam logic [1:0] OOR_RESP = 2'b10;
`else
    localparam logic [1:0] OOR_RESP = 2'b00;
`endif

    int errors = 0;
    int checks = 0;
    logic [1:0]  bq[$];
    logic [33:0] rq[$];

    s_axil_regfile #(
        .S_AXI_ADDR_WIDTH(8),
        .S_AXI_DATA_WIDTH(32),
        .NUM_REGS(4)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWADDR(AWADDR), .AWVALID(AWVALID), .AWREADY(AWREADY),
        .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
        .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
        .ARADDR(ARADDR), .ARVALID(ARVALID), .ARREADY(ARREADY),
        .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
        .reg_out(reg_out), .wr_pulse(wr_pulse)
    );

    always #5 ACLK = ~ACLK;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    // Response monitor: a handshake happens at the next rising edge.
    always @(negedge ACLK) begin
        if (!ARESET && BVALID && BREADY) begin
            if (bq.size() == 0) chk("b_unexpected", 128'(BVALID), 128'd0);
            else chk("bresp", 128'(BRESP), 128'(bq.pop_front()));
        end
        if (!ARESET && RVALID && RREADY) begin
            if (rq.size() == 0) chk("r_unexpected", 128'(RVALID), 128'd0);
            else chk("rresp_rdata", 128'({RRESP, RDATA}), 128'(rq.pop_front()));
        end
    end

    task automatic do_reset;
        ARESET = 1'b1;
        tick();
        ARESET = 1'b0;
    endtask

    task automatic do_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                            input logic [1:0] eb, input logic [3:0] ep);
        AWADDR = a; AWVALID = 1'b1; WDATA = d; WSTRB = s; WVALID = 1'b1;
        bq.push_back(eb);
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        tick();
        chk("wr_pulse", 128'(wr_pulse), 128'(ep));
        chk("bvalid_set", 128'(BVALID), 128'd1);
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        chk("wr_pulse_clear", 128'(wr_pulse), 128'd0);
    endtask

    task automatic do_read(input logic [7:0] a, input logic [31:0] ed, input logic [1:0] er);
        ARADDR = a; ARVALID = 1'b1;
        rq.push_back({er, ed});
        tick();
        ARVALID = 1'b0;
        chk("rvalid_set", 128'(RVALID), 128'd1);
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
    endtask

    initial begin
        ARESET = 1'b1; AWADDR = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
        BREADY = 1'b0; ARADDR = '0; ARVALID = 1'b0; RREADY = 1'b0;
        tick();
        do_reset();
        chk("rst_awready", 128'(AWREADY), 128'd1);
        chk("rst_wready", 128'(WREADY), 128'd1);
        chk("rst_arready", 128'(ARREADY), 128'd1);
        chk("rst_bvalid", 128'(BVALID), 128'd0);
        chk("rst_rvalid", 128'(RVALID), 128'd0);
        chk("rst_reg_out", reg_out, 128'd0);
        chk("rst_wr_pulse", 128'(wr_pulse), 128'd0);

        // Same-cycle AW+W to register 2
        do_write(8'h08, 32'hDEADBEEF, 4'hF, 2'b00, 4'b0100);
        chk("t1_reg_out", reg_out, {32'h0, 32'hDEADBEEF, 32'h0, 32'h0});
        chk("t1_awready_back", 128'(AWREADY), 128'd1);

        // W three cycles ahead of AW, B stalled five cycles
        WDATA = 32'h12345678; WSTRB = 4'hF; WVALID = 1'b1;
        tick();
        WVALID = 1'b0;
        chk("t2_wready_held", 128'(WREADY), 128'd0);
        tick();
        tick();
        AWADDR = 8'h04; AWVALID = 1'b1;
        bq.push_back(2'b00);
        tick();
        AWVALID = 1'b0;
        tick();
        chk("t2_reg_out", reg_out, {32'h0, 32'hDEADBEEF, 32'h12345678, 32'h0});
        chk("t2_wr_pulse", 128'(wr_pulse), 128'd2);
        for (int i = 0; i < 5; i++) begin
            chk("t2_bvalid_hold", 128'(BVALID), 128'd1);
            chk("t2_awready_low", 128'(AWREADY), 128'd0);
            chk("t2_wready_low", 128'(WREADY), 128'd0);
            if (i < 4) tick();
        end
        BREADY = 1'b1;
        tick();
        BREADY = 1'b0;
        chk("t2_bvalid_clr", 128'(BVALID), 128'd0);
        chk("t2_awready_up", 128'(AWREADY), 128'd1);
        chk("t2_wready_up", 128'(WREADY), 128'd1);

        // Byte strobes
        do_write(8'h0C, 32'hAABBCCDD, 4'hF, 2'b00, 4'b1000);
        do_write(8'h0C, 32'h11223344, 4'h5, 2'b00, 4'b1000);
        chk("t3_reg_out", reg_out, {32'hAA22CC44, 32'hDEADBEEF, 32'h12345678, 32'h0});

        // Read colliding with a commit returns the old value
        do_reset();
        AWADDR = 8'h0C; AWVALID = 1'b1; WDATA = 32'h55; WSTRB = 4'hF; WVALID = 1'b1;
        bq.push_back(2'b00);
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        ARADDR = 8'h0C; ARVALID = 1'b1;
        rq.push_back({2'b00, 32'h0});
        tick();
        ARVALID = 1'b0;
        chk("t4_reg3", reg_out, {32'h55, 32'h0, 32'h0, 32'h0});
        chk("t4_wr_pulse", 128'(wr_pulse), 128'd8);
        BREADY = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("t4_rvalid_hold", 128'(RVALID), 128'd1);
            chk("t4_rdata_hold", 128'(RDATA), 128'd0);
            chk("t4_arready_low", 128'(ARREADY), 128'd0);
            tick();
        end
        BREADY = 1'b0;
        RREADY = 1'b1;
        tick();
        RREADY = 1'b0;
        chk("t4_arready_up", 128'(ARREADY), 128'd1);
        do_read(8'h0C, 32'h55, 2'b00);

        // Out-of-range write and read
        do_write(8'h20, 32'hCAFEF00D, 4'hF, OOR_RESP, 4'b0000);
        chk("t5_reg_out", reg_out, {32'h55, 32'h0, 32'h0, 32'h0});
        do_read(8'h20, 32'h0, OOR_RESP);

        // Reset with both beats held and the commit due on the reset edge
        AWADDR = 8'h04; AWVALID = 1'b1; WDATA = 32'h99; WSTRB = 4'hF; WVALID = 1'b1;
        tick();
        AWVALID = 1'b0; WVALID = 1'b0;
        do_reset();
        chk("t6_bvalid", 128'(BVALID), 128'd0);
        chk("t6_awready", 128'(AWREADY), 128'd1);
        chk("t6_reg_out", reg_out, 128'd0);
        chk("t6_wr_pulse", 128'(wr_pulse), 128'd0);
        tick();
        chk("t6_bvalid_later", 128'(BVALID), 128'd0);
        chk("t6_wr_pulse_later", 128'(wr_pulse), 128'd0);
        chk("t6_reg_out_later", reg_out, 128'd0);

        // Zero-strobe commit still responds and pulses
        do_write(8'h00, 32'hFFFFFFFF, 4'h0, 2'b00, 4'b0001);
        chk("t7_reg_out", reg_out, 128'd0);

        tick();
        chk("bq_drained", 128'(bq.size()), 128'd0);
        chk("rq_drained", 128'(rq.size()), 128'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/s_axil_regfile.md
S_AXIL_REGFILE -- requirements
Module: s_axil_regfile

Interface
REQ-001 The block SHALL run on the single clock ACLK. Reset SHALL be ARESET, synchronous and active-high.
REQ-002 Parameter S_AXI_ADDR_WIDTH, default 8: AXI-Lite byte-address width.
REQ-003 Parameter S_AXI_DATA_WIDTH, default 32: data width; legal values are 32 and 64.
REQ-004 Parameter NUM_REGS, default 16: register count; legal range is 1 to 2^(S_AXI_ADDR_WIDTH-log2(S_AXI_DATA_WIDTH/8)).
REQ-005 The ports SHALL be as follows (AW=S_AXI_ADDR_WIDTH, DW=S_AXI_DATA_WIDTH):
- ACLK  in  1  clock
- ARESET  in  1  synchronous active-high reset
- AWADDR  in  AW  write address; AWVALID in 1; AWREADY out 1
- WDATA  in  DW  write data; WSTRB  in  DW/8  byte strobes; WVALID in 1; WREADY out 1
- BRESP  out  2  write response; BVALID out 1; BREADY in 1
- ARADDR  in  AW  read address; ARVALID in 1; ARREADY out 1
- RDATA  out  DW  read data; RRESP out 2; RVALID out 1; RREADY in 1
- reg_out  out  NUM_REGS*DW  all registers flattened; register k is at bits [k*DW +: DW]
- wr_pulse  out  NUM_REGS  one-cycle strobe, bit k set on the cycle after register k is committed

Function
REQ-006 Register index SHALL be addr[AW-1:log2(DW/8)]. The low byte-offset bits SHALL be ignored.
REQ-007 An index >= NUM_REGS SHALL be out-of-range.
REQ-008 AWREADY SHALL equal !aw_held && !BVALID.
REQ-009 WREADY SHALL equal !w_held && !BVALID.
REQ-010 AW and W SHALL be accepted independently, in either order or in the same cycle.
REQ-011 Each accepted address or data beat SHALL be captured into its own holding register (address; data plus strobes).
REQ-012 Commit SHALL occur on the first edge at which aw_held && w_held. At that edge:
- the target register updates byte-wise, with only lanes where WSTRB[b]=1 changing;
- BVALID is set;
- aw_held and w_held clear;
- the wr_pulse bit for the target register is set for exactly one cycle.
REQ-013 Write latency: with AW and W handshaked at edge N, the register, reg_out and BVALID SHALL update at edge N+1.
REQ-014 BVALID SHALL stay high until the edge where BREADY=1, and SHALL clear on that edge. AWREADY and WREADY SHALL return high in the following cycle.
REQ-015 An AW or W beat SHALL NOT be accepted while BVALID=1.
REQ-016 A commit with WSTRB=0 SHALL leave the register unchanged. It SHALL still complete with BVALID and wr_pulse.
REQ-017 ARREADY SHALL equal !RVALID.
REQ-018 On an AR handshake at edge N, RDATA, RRESP and RVALID=1 SHALL be registered at edge N. RDATA SHALL hold the register value before any commit at that same edge (old value returned).
REQ-019 RDATA and RRESP SHALL be held stable while RVALID=1 && RREADY=0. RVALID SHALL clear on the edge where RREADY=1.
REQ-020 The read and write paths SHALL be fully independent and SHALL operate concurrently.
REQ-021 BRESP and RRESP SHALL be 2'b00 (OKAY) for in-range accesses.

Reset
REQ-022 On ARESET=1 at an edge, the following SHALL be 0 from the next cycle:
- all registers and reg_out;
- wr_pulse, BVALID, RVALID, RDATA, BRESP and RRESP;
- aw_held and w_held.
REQ-023 AWREADY, WREADY and ARREADY SHALL be 1 from the cycle after a reset edge.
REQ-024 Reset mid-transaction SHALL abandon all held and pending transfers without committing any write.

Configuration
REQ-025 With macro S_AXIL_REGFILE_SLVERR_EN defined, out-of-range accesses SHALL behave as follows:
- an out-of-range write SHALL NOT modify any register;
- it SHALL pulse no wr_pulse bit;
- it SHALL return BRESP=2'b10 (SLVERR);
- an out-of-range read SHALL return RDATA=0 and RRESP=2'b10.
REQ-026 Without the macro, an out-of-range write SHALL be dropped silently with BRESP=2'b00, and an out-of-range read SHALL return RDATA=0 with RRESP=2'b00. No SLVERR logic SHALL be present.

Verification
REQ-027 Reset, then AW=0x08 and W=0xDEADBEEF with WSTRB=0xF in the same cycle -> reg_out[2] reads 0xDEADBEEF one edge later, wr_pulse=0x0004 for one cycle, BVALID=1 with BRESP=00.
REQ-028 W=0x12345678 presented 3 cycles before AW=0x04, then BREADY held 0 for 5 cycles -> register 1 equals 0x12345678, BVALID stays high 5 cycles, and AWREADY and WREADY stay 0 until after B handshake.
REQ-029 Register 3=0xAABBCCDD, then write 0x11223344 with WSTRB=0x5 -> register 3 equals 0xAA22CC44.
REQ-030 AR=0x0C at the same edge as a commit of 0x55 to register 3 (old value 0x0) -> RDATA=0x0, and a following read returns 0x55. RREADY held 0 for 4 cycles keeps RDATA stable.
REQ-031 NUM_REGS=4, write and read to 0x20 -> with the macro: BRESP=10, RRESP=10, RDATA=0, no register changes. Without the macro: BRESP=00, RRESP=00, RDATA=0.
REQ-032 ARESET asserted while aw_held=1 and BVALID pending -> next cycle BVALID=0, AWREADY=1, all reg_out=0, and no wr_pulse.
